isp_ztest: RTL and testbench
============================

ISP_ZTEST -- requirements
Module: isp_ztest

Interface
REQ-001 SHALL have parameter TILE_DIM, default 32, pixels per tile edge; only 32 is supported.
REQ-002 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  pulse; begins a tile pass when sampled in IDLE.
REQ-005 SHALL have port clear  in  1  pulse; begins a tile Z-clear when sampled in IDLE.
REQ-006 SHALL have port clear_z  in  32  signed Z value written by clear.
REQ-007 SHALL have port tile_x  in  5  tile column; sampled with start.
REQ-008 SHALL have port tile_y  in  5  tile row; sampled with start.
REQ-009 SHALL have port depth_mode  in  3  compare mode; sampled with start.
REQ-010 SHALL have port z_write_dis  in  1  suppresses Z writeback; sampled with start.
REQ-011 SHALL have port x_ps  out  11  signed screen X driven to the plane interpolator.
REQ-012 SHALL have port y_ps  out  11  signed screen Y driven to the plane interpolator.
REQ-013 SHALL have port interp  in  32  signed interpolated Z, combinationally valid in the same cycle as x_ps/y_ps.
REQ-014 SHALL have ports pix_valid out 1, pix_x out 5, pix_y out 5, pix_z out 32 (signed), pix_pass out 1: per-pixel result.
REQ-015 SHALL have ports busy out 1 (state not IDLE) and done out 1 (one-cycle completion pulse).

Function
REQ-016 SHALL implement states IDLE, CLEAR, RUN, DRAIN.
REQ-017 IDLE: clear=1 -> CLEAR; else start=1 -> RUN; when both are high, clear wins and start is dropped.
REQ-018 start/clear outside IDLE SHALL be ignored, with no queuing.
REQ-019 CLEAR SHALL write clear_z (sampled at entry) to addresses 0..1023, one per cycle, then pulse done and return to IDLE: busy for 1024 cycles.
REQ-020 RUN SHALL step a 10-bit counter k=0..1023, one per cycle, x fastest: lx=k[4:0], ly=k[9:5].
REQ-021 In RUN: x_ps={tile_x,lx}, y_ps={tile_y,ly}, zero-extended to 11 bits. Outside RUN, x_ps and y_ps SHALL be 0.
REQ-022 Stage 1 (cycle of k): register interp, lx, ly; issue synchronous Z-RAM read at address {ly,lx}.
REQ-023 Stage 2 (next cycle): compare new=registered interp against old=RAM data as signed 32-bit; register the result.
REQ-024 Stage 3: pix_valid=1 with pix_x, pix_y, pix_z=new, pix_pass. If pass and !z_write_dis, write new to {ly,lx} in the same cycle.
REQ-025 Result latency: pixel k's pix_valid SHALL appear exactly 3 cycles after the cycle k drives x_ps.
REQ-026 depth_mode: 0 never, 1 new<old, 2 new==old, 3 new<=old, 4 new>old, 5 new!=old, 6 new>=old, 7 always.
REQ-027 Consecutive pixels SHALL be at distinct addresses, so no read-after-write forwarding is required within a pass. A pass following a pass or clear SHALL observe all prior writes.
REQ-028 After k=1023, RUN -> DRAIN. DRAIN SHALL last until the last pix_valid; done pulses in the same cycle as pixel 1023's pix_valid; then IDLE.
REQ-029 There is no backpressure: the consumer SHALL accept every pix_valid cycle.

Reset
REQ-030 reset SHALL force IDLE and zero busy, done, pix_valid, pix_x, pix_y, pix_z, pix_pass, x_ps, y_ps and all pipeline valids, including mid-pass or mid-clear.
REQ-031 Z-RAM contents SHALL NOT be reset and are undefined until a CLEAR completes; no write SHALL occur in the cycle reset is high.

Structure
REQ-032 Package pvr_pkg SHALL hold TILE_DIM, the depth_mode encodings, and the state encoding.
REQ-033 The Z store SHALL be a sub-module ztile_ram: 1024x32 simple dual-port, one write port and one synchronous-read port, inferable as block RAM.

Verification
REQ-034 Reset, then clear with clear_z=0 -> busy 1024 cycles, one done pulse, no pix_valid.
REQ-035 Constant-Z pass: start, tile_x=2, tile_y=1, mode 4 (greater), interp=0x100 -> 1024 pix_valid, first with x_ps=64, y_ps=32 three cycles earlier, all pix_pass=1; a repeat pass with the same values -> all pix_pass=0.
REQ-036 Ramp pass: interp=x_ps, mode 1 (less), after clear_z=16 -> pix_pass=1 exactly for lx<16 when tile_x=0; RAM then holds lx for those pixels and 16 elsewhere.
REQ-037 z_write_dis=1, mode 7 (always) -> all pix_pass=1; a following mode 2 (equal) pass with interp=clear_z -> all pix_pass=1, proving no writes occurred.
REQ-038 Corner cases: start and clear in the same cycle -> clear only; start during RUN -> ignored; reset at k=500 -> outputs 0 next cycle, IDLE, and a new start runs a full 1024 pixels.

Source files
------------

// File: rtl/pvr_pkg.sv
// Shared constants for the tile Z-test block: tile geometry, depth compare
// encodings, controller state encoding and the depth compare function.
package pvr_pkg;

    localparam int TILE_DIM = 32;
    localparam int TILE_AW  = 2 * $clog2(TILE_DIM);
    localparam int TILE_PIX = TILE_DIM * TILE_DIM;

    localparam logic [2:0] DM_NEVER   = 3'd0;
    localparam logic [2:0] DM_LESS    = 3'd1;
    localparam logic [2:0] DM_EQUAL   = 3'd2;
    localparam logic [2:0] DM_LEQUAL  = 3'd3;
    localparam logic [2:0] DM_GREATER = 3'd4;
    localparam logic [2:0] DM_NEQUAL  = 3'd5;
    localparam logic [2:0] DM_GEQUAL  = 3'd6;
    localparam logic [2:0] DM_ALWAYS  = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Signed comparison of the incoming Z against the stored Z.
    function automatic logic depth_test(input logic [2:0] mode,
                                        input logic signed [31:0] new_z,
                                        input logic signed [31:0] old_z);
        logic res;
        case (mode)
            DM_NEVER:   res = 1'b0;
            DM_LESS:    res = (new_z <  old_z);
            DM_EQUAL:   res = (new_z == old_z);
            DM_LEQUAL:  res = (new_z <= old_z);
            DM_GREATER: res = (new_z >  old_z);
            DM_NEQUAL:  res = (new_z != old_z);
            DM_GEQUAL:  res = (new_z >= old_z);
            default:    res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ztile_ram.sv
// Per-tile Z store: simple dual-port RAM, one write port, one registered read.
module ztile_ram
    import pvr_pkg::*;
#(
    parameter int AW = TILE_AW,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // Write port; contents are deliberately never reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Synchronous read port, data available the cycle after the address.
    always_ff @(posedge clock) begin
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/isp_ztest.sv
// Tile Z-test engine: clears a 32x32 Z tile or walks it pixel by pixel,
// comparing interpolated Z against stored Z through a 3-stage pipeline.
module isp_ztest
    import pvr_pkg::*;
#(
    parameter int TILE_DIM = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic signed [31:0] clear_z,
    input  logic [4:0]         tile_x,
    input  logic [4:0]         tile_y,
    input  logic [2:0]         depth_mode,
    input  logic               z_write_dis,
    output logic signed [10:0] x_ps,
    output logic signed [10:0] y_ps,
    input  logic signed [31:0] interp,
    output logic               pix_valid,
    output logic [4:0]         pix_x,
    output logic [4:0]         pix_y,
    output logic signed [31:0] pix_z,
    output logic               pix_pass,
    output logic               busy,
    output logic               done
);

    localparam int LW = $clog2(TILE_DIM);
    localparam int AW = 2 * LW;
    localparam logic [AW-1:0] LAST_K = '1;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [31:0]   cz_q, cz_d;
    logic [4:0]    tx_q, tx_d, ty_q, ty_d;
    logic [2:0]    mode_q, mode_d;
    logic          zwd_q, zwd_d;

    logic          s1_valid_q, s1_valid_d;
    logic [31:0]   s1_z_q, s1_z_d;
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic          s2_valid_q, s2_valid_d;
    logic          s2_pass_q, s2_pass_d;
    logic [31:0]   s2_z_q, s2_z_d;
    logic [AW-1:0] s2_addr_q, s2_addr_d;
    logic          pv_q, pv_d;
    logic          ppass_q, ppass_d;
    logic [31:0]   pz_q, pz_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          done_q, done_d;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          in_run, in_clear;

    assign in_run   = (state_q == ST_RUN);
    assign in_clear = (state_q == ST_CLEAR);

    // Controller: command acceptance in IDLE, pixel counter, drain exit.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cz_d    = cz_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        mode_d  = mode_q;
        zwd_d   = zwd_q;
        case (state_q)
            ST_IDLE: begin
                k_d = '0;
                if (clear) begin
                    state_d = ST_CLEAR;
                    cz_d    = clear_z;
                end else if (start) begin
                    state_d = ST_RUN;
                    tx_d    = tile_x;
                    ty_d    = tile_y;
                    mode_d  = depth_mode;
                    zwd_d   = z_write_dis;
                end
            end
            ST_CLEAR: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST_K) state_d = ST_IDLE;
            end
            ST_RUN: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST_K) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // done_q marks the cycle pixel 1023 is presented.
                if (done_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pipeline: stage 1 captures interp/address, stage 2 compares with RAM
    // data, stage 3 presents the result and drives writeback.
    always_comb begin
        s1_valid_d = in_run;
        s1_z_d     = interp;
        s1_addr_d  = k_q;
        s2_valid_d = s1_valid_q;
        s2_pass_d  = depth_test(mode_q, s1_z_q, ram_rdata);
        s2_z_d     = s1_z_q;
        s2_addr_d  = s1_addr_q;
        pv_d       = s2_valid_q;
        ppass_d    = s2_pass_q;
        pz_d       = s2_z_q;
        paddr_d    = s2_addr_q;
        done_d     = (s2_valid_q && (s2_addr_q == LAST_K)) ||
                     (in_clear && (k_q == LAST_K));
    end

    // State and pipeline registers; synchronous reset clears every valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            cz_q       <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            mode_q     <= '0;
            zwd_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_z_q     <= '0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_pass_q  <= 1'b0;
            s2_z_q     <= '0;
            s2_addr_q  <= '0;
            pv_q       <= 1'b0;
            ppass_q    <= 1'b0;
            pz_q       <= '0;
            paddr_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cz_q       <= cz_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            mode_q     <= mode_d;
            zwd_q      <= zwd_d;
            s1_valid_q <= s1_valid_d;
            s1_z_q     <= s1_z_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_pass_q  <= s2_pass_d;
            s2_z_q     <= s2_z_d;
            s2_addr_q  <= s2_addr_d;
            pv_q       <= pv_d;
            ppass_q    <= ppass_d;
            pz_q       <= pz_d;
            paddr_q    <= paddr_d;
            done_q     <= done_d;
        end
    end

    // Clear owns the write port while active; otherwise stage 3 writes back.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = paddr_q;
        ram_wdata = pz_q;
        if (!reset) begin
            if (in_clear) begin
                ram_we    = 1'b1;
                ram_waddr = k_q;
                ram_wdata = cz_q;
            end else begin
                ram_we = pv_q && ppass_q && !zwd_q;
            end
        end
    end

    ztile_ram #(.AW(AW), .DW(32)) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (k_q),
        .rdata (ram_rdata)
    );

    assign x_ps      = in_run ? {1'b0, tx_q, k_q[LW-1:0]}  : '0;
    assign y_ps      = in_run ? {1'b0, ty_q, k_q[AW-1:LW]} : '0;
    assign pix_valid = pv_q;
    assign pix_x     = paddr_q[LW-1:0];
    assign pix_y     = paddr_q[AW-1:LW];
    assign pix_z     = pz_q;
    assign pix_pass  = ppass_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_isp_ztest.sv
// Directed bench for isp_ztest with a reference Z-tile model.
module tb_isp_ztest;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               clear = 1'b0;
    logic signed [31:0] clear_z = '0;
    logic [4:0]         tile_x = '0;
    logic [4:0]         tile_y = '0;
    logic [2:0]         depth_mode = '0;
    logic               z_write_dis = 1'b0;
    logic signed [10:0] x_ps, y_ps;
    logic signed [31:0] interp;
    logic               pix_valid;
    logic [4:0]         pix_x, pix_y;
    logic signed [31:0] pix_z;
    logic               pix_pass;
    logic               busy, done;

    logic               ramp_sel = 1'b0;
    logic signed [31:0] const_z = '0;
    logic signed [31:0] zmodel [0:1023];
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    // Plane interpolator stand-in: either a constant or Z = screen X.
    always_comb interp = ramp_sel ? {{21{x_ps[10]}}, x_ps} : const_z;

    isp_ztest #(.TILE_DIM(32)) dut (
        .clock(clock), .reset(reset), .start(start), .clear(clear),
        .clear_z(clear_z), .tile_x(tile_x), .tile_y(tile_y),
        .depth_mode(depth_mode), .z_write_dis(z_write_dis),
        .x_ps(x_ps), .y_ps(y_ps), .interp(interp),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_z(pix_z), .pix_pass(pix_pass), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        assert (act === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, expv);
        end
    endtask

    function automatic logic ref_depth(input logic [2:0] m,
                                       input logic signed [31:0] n,
                                       input logic signed [31:0] o);
        case (m)
            3'd0: return 1'b0;
            3'd1: return n < o;
            3'd2: return n == o;
            3'd3: return n <= o;
            3'd4: return n > o;
            3'd5: return n != o;
            3'd6: return n >= o;
            default: return 1'b1;
        endcase
    endfunction

    // Clear with optional simultaneous start; start must be dropped.
    task automatic do_clear(input string tag, input logic signed [31:0] cz, input logic with_start);
        int nbusy = 0, ndone = 0, nvalid = 0, nxps = 0;
        clear_z = cz; clear = 1'b1; start = with_start;
        tile_x = 5'd3; tile_y = 5'd3;
        tick();
        clear = 1'b0; start = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (busy) nbusy++;
            if (pix_valid) nvalid++;
            if (x_ps != 0) nxps++;
            if (done) ndone++;
            tick();
            if (ndone != 0) break;
        end
        for (int i = 0; i < 1024; i++) zmodel[i] = cz;
        $display("clear %s: busy=%0d done=%0d pix_valid=%0d", tag, nbusy, ndone, nvalid);
        chk({tag, "_busy"}, 64'(nbusy), 64'd1024);
        chk({tag, "_done"}, 64'(ndone), 64'd1);
        chk({tag, "_novalid"}, 64'(nvalid + nxps), 64'd0);
    endtask

    // Full tile pass checked pixel by pixel against the model.
    task automatic do_pass(input string tag, input int tx, input int ty,
                           input logic [2:0] mode, input logic zwd, input logic ramp,
                           input logic signed [31:0] cz, input int exp_cnt, input int inj_at);
        int nbusy = 0, ndone = 0, npix = 0, npass = 0, first_v = -1;
        logic signed [31:0] nz;
        logic p;
        tile_x = tx[4:0]; tile_y = ty[4:0]; depth_mode = mode; z_write_dis = zwd;
        ramp_sel = ramp; const_z = cz; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (cyc == 0) begin
                chk({tag, "_xps0"}, 64'(x_ps), 64'(tx * 32));
                chk({tag, "_yps0"}, 64'(y_ps), 64'(ty * 32));
            end
            if (busy) nbusy++;
            if (pix_valid) begin
                if (first_v < 0) first_v = cyc;
                nz = ramp ? 32'(tx * 32 + npix % 32) : cz;
                p = ref_depth(mode, nz, zmodel[npix]);
                if (p && !zwd) zmodel[npix] = nz;
                if (p) npass++;
                chk({tag, "_pix"}, {pix_x, pix_y, pix_z, pix_pass},
                    {5'(npix % 32), 5'(npix / 32), nz, p});
                npix++;
            end
            if (done) begin
                ndone++;
                chk({tag, "_done_align"}, {pix_valid, pix_x, pix_y}, {1'b1, 5'd31, 5'd31});
            end
            if (cyc == inj_at) begin
                start = 1'b1; tile_x = 5'd7; tile_y = 5'd9; depth_mode = 3'd0;
            end
            tick();
            if (cyc == inj_at) begin
                start = 1'b0; tile_x = tx[4:0]; tile_y = ty[4:0]; depth_mode = mode;
            end
            if (ndone != 0) break;
        end
        $display("pass %s: pixels=%0d passes=%0d busy=%0d latency=%0d", tag, npix, npass, nbusy, first_v);
        chk({tag, "_latency"}, 64'(first_v), 64'd3);
        chk({tag, "_npix"}, 64'(npix), 64'd1024);
        chk({tag, "_npass"}, 64'(npass), 64'(exp_cnt));
        chk({tag, "_done"}, 64'(ndone), 64'd1);
        chk({tag, "_busy"}, 64'(nbusy), 64'd1027);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        $display("reset: busy=%0b done=%0b pix_valid=%0b x_ps=%0d", busy, done, pix_valid, x_ps);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outs", {done, pix_valid, pix_pass, pix_x, pix_y, pix_z}, 64'd0);
        chk("rst_ps", {x_ps, y_ps}, 64'd0);

        do_clear("c0", 32'sd0, 1'b0);
        do_pass("gt_const", 2, 1, 3'd4, 1'b0, 1'b0, 32'sh100, 1024, -1);
        do_pass("gt_repeat", 2, 1, 3'd4, 1'b0, 1'b0, 32'sh100, 0, -1);

        do_clear("c16", 32'sd16, 1'b0);
        do_pass("ramp_lt", 0, 0, 3'd1, 1'b0, 1'b1, 32'sd0, 512, 10);
        do_pass("ramp_eq", 0, 0, 3'd2, 1'b0, 1'b1, 32'sd0, 544, -1);

        do_clear("cneg", -32'sd5, 1'b0);
        do_pass("always_nowr", 1, 2, 3'd7, 1'b1, 1'b0, 32'sd7, 1024, -1);
        do_pass("eq_clear", 1, 2, 3'd2, 1'b0, 1'b0, -32'sd5, 1024, -1);
        do_pass("lt_signed", 1, 2, 3'd1, 1'b0, 1'b0, 32'sd3, 0, -1);

        do_clear("clr_start", 32'sd9, 1'b1);
        do_pass("eq9", 4, 5, 3'd2, 1'b0, 1'b0, 32'sd9, 1024, -1);

        // Reset in the middle of a pass at k=500.
        tile_x = 5'd3; tile_y = 5'd4; depth_mode = 3'd7; z_write_dis = 1'b1;
        ramp_sel = 1'b0; const_z = 32'sd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) tick();
        chk("mid_xps", 64'(x_ps), 64'd116);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("midreset: busy=%0b pix_valid=%0b x_ps=%0d", busy, pix_valid, x_ps);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_outs", {done, pix_valid, pix_pass, pix_x, pix_y, pix_z}, 64'd0);
        chk("mid_ps", {x_ps, y_ps}, 64'd0);
        tick(); tick(); tick();
        chk("mid_quiet", {pix_valid, done, busy}, 64'd0);
        do_pass("after_rst", 3, 4, 3'd2, 1'b0, 1'b0, 32'sd9, 1024, -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
